modbus_rtu_frame_rx: RTL and testbench

Modbus RTU frame assembler that sits directly downstream of the UART byte receiver. It consumes the receiver's byte strobe and data, delimits frames using the RTU t1.5/t3.5 silence rules, and stores each frame in an internal buffer. It verifies CRC-16 on the fly and presents complete good frames to the slave protocol engine through a synchronous read port with a valid/ack handshake.

---
 rtl/modbus_rtu_frame_rx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_modbus_rtu_frame_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_frame_rx.sv
// modbus_rtu_frame_rx: Modbus RTU frame assembler fed by a UART byte receiver.
// Frames are delimited by the t1.5/t3.5 silence rules and stored in an internal
// buffer. CRC-16 (reflected 0xA001) is checked bit-serially as bytes arrive.
// Good frames are presented through a registered read port with a valid/ack handshake.
// Optional feature: define ADDR_FILTER_EN to silently discard CRC-good frames whose
// address byte is neither SLAVE_ADDR nor broadcast (8'h00).
`timescale 1ns/1ps
module modbus_rtu_frame_rx #(
   parameter int unsigned CLK_FREQ   = 32'd50000000,
   parameter int unsigned BAUD_RATE  = 32'd9600,
   parameter int unsigned MAX_LEN    = 32'd256,
   parameter logic [7:0]  SLAVE_ADDR = 8'h01
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       frm_valid,
   output logic [8:0] frm_len,
   input  logic       frm_ack,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       err_vld,
   output logic [2:0] err_code
);

   // Character timing in clock cycles (11-bit characters at low baud, fixed us above 19200)
   localparam longint unsigned CLK_L  = 64'(CLK_FREQ);
   localparam longint unsigned BAUD_L = 64'(BAUD_RATE);
   localparam longint unsigned T15_L  = (BAUD_L <= 64'd19200) ?
                                        (CLK_L * 64'd33) / (64'd2 * BAUD_L) :
                                        (CLK_L / 64'd1000000) * 64'd750;
   localparam longint unsigned T35_L  = (BAUD_L <= 64'd19200) ?
                                        (CLK_L * 64'd77) / (64'd2 * BAUD_L) :
                                        (CLK_L / 64'd1000000) * 64'd1750;
   localparam logic [23:0] T15 = 24'(T15_L);
   localparam logic [23:0] T35 = 24'(T35_L);

   localparam int unsigned AW        = (MAX_LEN > 32'd1) ? $clog2(MAX_LEN) : 32'd1;
   localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);

   localparam logic [2:0] ERR_CRC   = 3'd0;
   localparam logic [2:0] ERR_SHORT = 3'd1;
   localparam logic [2:0] ERR_OVF   = 3'd2;
   localparam logic [2:0] ERR_T15   = 3'd3;
   localparam logic [2:0] ERR_BUSY  = 3'd4;

`ifdef ADDR_FILTER_EN
   localparam logic FILTER_ON = 1'b1;
`else
   localparam logic FILTER_ON = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_RECV  = 3'd2,
      ST_GAP   = 3'd3,
      ST_CHECK = 3'd4,
      ST_HOLD  = 3'd5
   } state_t;

   // One bit of the reflected CRC-16 (poly 0xA001), LSB-first data
   function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
      logic        fb;
      logic [15:0] nxt;
      fb  = crc[0] ^ din;
      nxt = {1'b0, crc[15:1]};
      if (fb) begin
         nxt = nxt ^ 16'hA001;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

   state_t        state_r;
   logic [23:0]   sil_r;
   logic [8:0]    len_r;
   logic          frm_valid_r;
   logic [8:0]    frm_len_r;
   logic          err_vld_r;
   logic [2:0]    err_code_r;
   logic          drop_r;
   logic [7:0]    first_byte_r;
   logic [15:0]   crc_r;
   logic [7:0]    crc_sh_r;
   logic [3:0]    crc_cnt_r;
   logic [7:0]    rd_data_r;
   logic [7:0]    mem_r [0:MAX_LEN-1];

   logic          wr_en_s;
   logic          crc_init_s;
   logic [AW-1:0] wr_idx_s;
   logic          addr_ok_s;

   assign frm_valid = frm_valid_r;
   assign frm_len   = frm_len_r;
   assign err_vld   = err_vld_r;
   assign err_code  = err_code_r;
   assign rd_data   = rd_data_r;

   // Address acceptance; constant true unless the filter is compiled in
   assign addr_ok_s = !FILTER_ON || (first_byte_r == SLAVE_ADDR) || (first_byte_r == 8'h00);

   // Decide whether the current byte is stored and whether it opens a new frame
   always_comb begin
      wr_en_s    = 1'b0;
      crc_init_s = 1'b0;
      wr_idx_s   = len_r[AW-1:0];
      if (rx_done && (state_r == ST_READY)) begin
         wr_en_s    = 1'b1;
         crc_init_s = 1'b1;
         wr_idx_s   = {AW{1'b0}};
      end else if (rx_done && (state_r == ST_RECV) && (len_r != MAX_LEN_W)) begin
         wr_en_s    = 1'b1;
      end else begin
         wr_en_s    = 1'b0;
      end
   end

   // Line silence counter: restarts on every byte, saturates at t3.5
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sil_r <= 24'd0;
      end else if (rx_done) begin
         sil_r <= 24'd0;
      end else if (sil_r != T35) begin
         sil_r <= sil_r + 24'd1;
      end else begin
         sil_r <= sil_r;
      end
   end

   // Bit-serial CRC engine: each stored byte is folded in over the 8 following cycles
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         crc_r     <= 16'hFFFF;
         crc_sh_r  <= 8'h00;
         crc_cnt_r <= 4'd0;
      end else if (wr_en_s) begin
         crc_sh_r  <= rx_data;
         crc_cnt_r <= 4'd8;
         if (crc_init_s) begin
            crc_r <= 16'hFFFF;
         end else begin
            crc_r <= crc_r;
         end
      end else if (crc_cnt_r != 4'd0) begin
         crc_r     <= crc16_bit(crc_r, crc_sh_r[0]);
         crc_sh_r  <= {1'b0, crc_sh_r[7:1]};
         crc_cnt_r <= crc_cnt_r - 4'd1;
      end else begin
         crc_r     <= crc_r;
      end
   end

   // Frame buffer write port (contents only meaningful while a frame is held)
   always_ff @(posedge clk_in) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= rx_data;
      end
   end

   // Registered read port, refreshed every cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_data_r <= 8'h00;
      end else begin
         rd_data_r <= mem_r[rd_addr[AW-1:0]];
      end
   end

   // Frame FSM with registered handshake and error outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r      <= ST_IDLE;
         len_r        <= 9'd0;
         frm_valid_r  <= 1'b0;
         frm_len_r    <= 9'd0;
         err_vld_r    <= 1'b0;
         err_code_r   <= 3'd0;
         drop_r       <= 1'b0;
         first_byte_r <= 8'h00;
      end else begin
         err_vld_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!rx_done && (sil_r == T35)) begin
                  state_r <= ST_READY;
               end
            end
            ST_READY: begin
               if (rx_done) begin
                  state_r      <= ST_RECV;
                  len_r        <= 9'd1;
                  first_byte_r <= rx_data;
               end
            end
            ST_RECV: begin
               if (rx_done) begin
                  if (len_r == MAX_LEN_W) begin
                     err_vld_r  <= 1'b1;
                     err_code_r <= ERR_OVF;
                     state_r    <= ST_IDLE;
                  end else begin
                     len_r <= len_r + 9'd1;
                  end
               end else if (sil_r == T15) begin
                  state_r <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (rx_done) begin
                  err_vld_r  <= 1'b1;
                  err_code_r <= ERR_T15;
                  state_r    <= ST_IDLE;
               end else if (sil_r == T35) begin
                  state_r <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (len_r < 9'd4) begin
                  err_vld_r  <= 1'b1;
                  err_code_r <= ERR_SHORT;
                  state_r    <= ST_READY;
               end else if (crc_r != 16'h0000) begin
                  err_vld_r  <= 1'b1;
                  err_code_r <= ERR_CRC;
                  state_r    <= ST_READY;
               end else if (!addr_ok_s) begin
                  state_r <= ST_READY;
               end else begin
                  frm_valid_r <= 1'b1;
                  frm_len_r   <= len_r;
                  drop_r      <= 1'b0;
                  state_r     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // A byte arriving with the ack is still a busy drop; the ack wins
               if (frm_ack) begin
                  frm_valid_r <= 1'b0;
                  drop_r      <= 1'b0;
                  state_r     <= ST_IDLE;
                  if (rx_done && !drop_r) begin
                     err_vld_r  <= 1'b1;
                     err_code_r <= ERR_BUSY;
                  end
               end else if (rx_done) begin
                  // Only the first byte of a dropped frame reports
                  if (!drop_r) begin
                     err_vld_r  <= 1'b1;
                     err_code_r <= ERR_BUSY;
                  end
                  drop_r <= 1'b1;
               end else if (sil_r == T35) begin
                  drop_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               frm_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Directed testbench for modbus_rtu_frame_rx at a scaled clock (192 kHz, 9600 baud):
// T15 = 192000*33/19200 = 330, T35 = 192000*77/19200 = 770, one character = 220 clocks.
`timescale 1ns/1ps
module tb_modbus_rtu_frame_rx;

   localparam int T15  = 330;
   localparam int T35  = 770;
   localparam int CHAR = 220;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frm_valid;
   logic [8:0] frm_len;
   logic       frm_ack;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       err_vld;
   logic [2:0] err_code;

   int n_vec     = 0;
   int n_miscmp  = 0;
   int err_pulses = 0;
   int e0;

   logic [7:0] tx_buf  [0:31];
   logic [7:0] exp_buf [0:31];
   int         tx_n;

   modbus_rtu_frame_rx #(
      .CLK_FREQ  (192000),
      .BAUD_RATE (9600),
      .MAX_LEN   (16),
      .SLAVE_ADDR(8'h01)
   ) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .frm_valid(frm_valid),
      .frm_len  (frm_len),
      .frm_ack  (frm_ack),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .err_vld  (err_vld),
      .err_code (err_code)
   );

   // Free-running clock
   always #5 clk_in = ~clk_in;

   // Count every error pulse, sampled mid-cycle
   always @(negedge clk_in) begin
      if (err_vld === 1'b1) err_pulses++;
   end

   // Watchdog so the run always terminates
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // Bench reference CRC-16/Modbus, byte-wise
   function automatic logic [15:0] crc16(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, tx_buf[i]};
         for (int b = 0; b < 8; b++) begin
            if (c[0]) c = {1'b0, c[15:1]} ^ 16'hA001;
            else      c = {1'b0, c[15:1]};
         end
      end
      return c;
   endfunction

   task automatic load8(input logic [63:0] bytes);
      for (int i = 0; i < 8; i++) tx_buf[i] = bytes[63-8*i -: 8];
      tx_n = 8;
   endtask

   task automatic load_with_crc(input logic [47:0] payload);
      logic [15:0] c;
      for (int i = 0; i < 6; i++) tx_buf[i] = payload[47-8*i -: 8];
      c = crc16(6);
      tx_buf[6] = c[7:0];
      tx_buf[7] = c[15:8];
      tx_n = 8;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick(1);
      rx_done = 1'b0;
   endtask

   task automatic send_frame(input int gap);
      for (int i = 0; i < tx_n; i++) begin
         send_byte(tx_buf[i]);
         if (i != tx_n - 1) tick(gap - 1);
      end
   endtask

   task automatic readback(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         rd_addr = 8'(i);
         tick(1);
         check_eq(tag, {8'h00, rd_data}, {8'h00, exp_buf[i]});
      end
   endtask

   // Frame just sent must be presented exactly T35+2 edges after its last byte
   task automatic expect_frame(input string tag);
      for (int i = 0; i < tx_n; i++) exp_buf[i] = tx_buf[i];
      tick(T35 + 1);
      check_eq({tag, "_valid_early"}, {15'd0, frm_valid}, 16'd0);
      tick(1);
      check_eq({tag, "_valid"}, {15'd0, frm_valid}, 16'd1);
      check_eq({tag, "_len"}, {7'd0, frm_len}, 16'(tx_n));
      readback({tag, "_data"}, tx_n);
   endtask

   // Frame-verdict error must pulse exactly T35+2 edges after the last byte
   task automatic expect_check_err(input string tag, input logic [2:0] code);
      tick(T35 + 1);
      check_eq({tag, "_err_early"}, {15'd0, err_vld}, 16'd0);
      tick(1);
      check_eq({tag, "_err_vld"}, {15'd0, err_vld}, 16'd1);
      check_eq({tag, "_err_code"}, {13'd0, err_code}, {13'd0, code});
      check_eq({tag, "_no_valid"}, {15'd0, frm_valid}, 16'd0);
   endtask

   task automatic do_ack(input string tag);
      frm_ack = 1'b1;
      tick(1);
      frm_ack = 1'b0;
      check_eq({tag, "_ack_drop"}, {15'd0, frm_valid}, 16'd0);
   endtask

   initial begin
      rst_in  = 1'b1;
      rx_data = 8'h00;
      rx_done = 1'b0;
      frm_ack = 1'b0;
      rd_addr = 8'h00;
      tick(3);
      check_eq("rst_valid",   {15'd0, frm_valid}, 16'd0);
      check_eq("rst_len",     {7'd0, frm_len},    16'd0);
      check_eq("rst_rd_data", {8'd0, rd_data},    16'd0);
      check_eq("rst_err_vld", {15'd0, err_vld},   16'd0);
      check_eq("rst_err_code",{13'd0, err_code},  16'd0);
      rst_in = 1'b0;

      // Good frame at one-character spacing
      tick(T35 + 5);
      load8(64'h01_03_00_00_00_01_84_0A);
      send_frame(CHAR);
      expect_frame("good");

      // Second frame while holding: one busy pulse, held frame untouched
      e0 = err_pulses;
      load8(64'h05_06_07_08_09_0A_0B_0C);
      send_byte(tx_buf[0]);
      check_eq("busy_err_vld",  {15'd0, err_vld},  16'd1);
      check_eq("busy_err_code", {13'd0, err_code}, 16'd4);
      for (int i = 1; i < 8; i++) begin
         tick(19);
         send_byte(tx_buf[i]);
      end
      tick(T35 + 10);
      check_eq("busy_one_pulse", 16'(err_pulses - e0), 16'd1);
      check_eq("busy_still_valid", {15'd0, frm_valid}, 16'd1);
      check_eq("busy_len", {7'd0, frm_len}, 16'd8);
      readback("busy_buf", 8);
      do_ack("busy");

      // After ack and T35, a new frame is presented
      tick(T35 + 5);
      load_with_crc(48'h01_06_00_01_00_03);
      send_frame(20);
      expect_frame("after_ack");

      // Ack and byte in the same cycle: ack wins, byte reported as busy drop
      frm_ack = 1'b1;
      send_byte(8'h55);
      frm_ack = 1'b0;
      check_eq("ackbyte_err_vld",  {15'd0, err_vld},  16'd1);
      check_eq("ackbyte_err_code", {13'd0, err_code}, 16'd4);
      check_eq("ackbyte_valid",    {15'd0, frm_valid}, 16'd0);

      // CRC error, then an immediate frame proves the block is back in READY
      tick(T35 + 5);
      load8(64'h01_03_00_00_00_01_84_0B);
      send_frame(20);
      expect_check_err("crc", 3'd0);
      load8(64'h01_03_00_00_00_01_84_0A);
      send_frame(20);
      expect_frame("post_crc");
      do_ack("post_crc");

      // t1.5 violation between bytes 3 and 4
      tick(T35 + 5);
      send_byte(8'h01); tick(19);
      send_byte(8'h03); tick(19);
      send_byte(8'h00); tick(T15 + 100 - 1);
      send_byte(8'h00);
      check_eq("t15_err_vld",  {15'd0, err_vld},  16'd1);
      check_eq("t15_err_code", {13'd0, err_code}, 16'd3);
      tick(T35 + 5);
      load8(64'h01_03_00_00_00_01_84_0A);
      send_frame(20);
      expect_frame("post_t15");
      do_ack("post_t15");

      // Short frame
      tick(T35 + 5);
      send_byte(8'h01); tick(19);
      send_byte(8'h03);
      expect_check_err("short", 3'd1);

      // Overflow: 17 bytes into a 16-byte buffer
      for (int i = 0; i < 17; i++) begin
         send_byte(8'(i + 16));
         if (i == 15) check_eq("ovf_16th_ok", {15'd0, err_vld}, 16'd0);
         if (i != 16) tick(19);
      end
      check_eq("ovf_err_vld",  {15'd0, err_vld},  16'd1);
      check_eq("ovf_err_code", {13'd0, err_code}, 16'd2);

      // Reset mid-frame: a frame starting without full T35 silence is ignored
      tick(T35 + 5);
      send_byte(8'h01); tick(19);
      send_byte(8'h03); tick(19);
      rst_in = 1'b1;
      tick(2);
      rst_in = 1'b0;
      e0 = err_pulses;
      load8(64'h01_03_00_00_00_01_84_0A);
      send_frame(20);
      tick(T35 + 10);
      check_eq("rst_mid_no_valid", {15'd0, frm_valid}, 16'd0);
      check_eq("rst_mid_no_err",   16'(err_pulses - e0), 16'd0);
      send_frame(20);
      expect_frame("post_rst");
      do_ack("post_rst");

      // Frame addressed to another station
      tick(T35 + 5);
      e0 = err_pulses;
      load8(64'h02_03_00_00_00_01_84_39);
      send_frame(20);
`ifdef ADDR_FILTER_EN
      tick(T35 + 10);
      check_eq("filt_no_valid", {15'd0, frm_valid}, 16'd0);
      check_eq("filt_no_err",   16'(err_pulses - e0), 16'd0);
`else
      expect_frame("addr02");
      do_ack("addr02");
      tick(T35 + 5);
`endif

      // Broadcast frame is always presented
      load_with_crc(48'h00_03_00_00_00_01);
      send_frame(20);
      expect_frame("bcast");
      do_ack("bcast");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
